// File: rtl/strassen_mem_pkg.sv
// Shared types and helpers for the Strassen memory server: run-state enum,
// lane count, and the read-pointer wrap function.
package strassen_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam int unsigned LANES = 3;

   // Next element index in a row-major stream of depth elements, wrapping to 0.
   function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/strassen_mat_store.sv
// DIM*DIM element register array: one synchronous write port and RD_PORTS
// registered read ports, each with its own enable (outputs hold when idle).
module strassen_mat_store #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned RD_PORTS   = 3
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr_en,
   input  logic [ADDR_WIDTH-1:0]                wr_addr,
   input  logic [DATA_WIDTH-1:0]                wr_data,
   input  logic [RD_PORTS-1:0]                  rd_en,
   input  logic [RD_PORTS-1:0][ADDR_WIDTH-1:0]  rd_addr,
   output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else begin
         for (int unsigned p = 0; p < RD_PORTS; p++) begin
            if (rd_en[p]) rd_data[p] <= mem[rd_addr[p]];
         end
      end
   end

endmodule

// File: rtl/strassen_mem_server.sv
// Memory-side responder for the Strassen accelerator: serves six read lanes
// from A/B, captures C results, and exposes a host load/start/readback port.
module strassen_mem_server
   import strassen_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned DIM        = 4,
   parameter int unsigned ADDR_WIDTH = $clog2(DIM*DIM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  host_wr_en,
   input  logic                  host_sel,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   input  logic                  host_start,
   input  logic [ADDR_WIDTH-1:0] host_rd_addr,
   output logic [DATA_WIDTH-1:0] host_rdata,
   input  logic [LANES-1:0]      A_read_en,
   input  logic [LANES-1:0]      B_read_en,
   output logic [DATA_WIDTH-1:0] A_in,
   output logic [DATA_WIDTH-1:0] A_in_1,
   output logic [DATA_WIDTH-1:0] A_in_2,
   output logic [DATA_WIDTH-1:0] B_in,
   output logic [DATA_WIDTH-1:0] B_in_1,
   output logic [DATA_WIDTH-1:0] B_in_2,
   input  logic [DATA_WIDTH-1:0] C_out,
   input  logic                  Write_en,
   input  logic                  load_out,
   output logic                  finished,
   output logic                  busy
);

   localparam int unsigned NN = DIM * DIM;

   state_t                               state;
   logic [LANES-1:0][ADDR_WIDTH-1:0]     a_ptr, b_ptr;
   logic [ADDR_WIDTH:0]                  c_ptr;
   logic                                 run, a_wr, b_wr, c_wr;
   logic [LANES-1:0]                     a_en, b_en;
   logic [LANES-1:0][DATA_WIDTH-1:0]     a_data, b_data;

   // A rewind cycle swallows every lane read and the result write.
   always_comb begin
      run  = (state == RUN);
      a_wr = host_wr_en && !run && !host_sel;
      b_wr = host_wr_en && !run && host_sel;
      a_en = (run && !load_out) ? A_read_en : '0;
      b_en = (run && !load_out) ? B_read_en : '0;
      c_wr = run && !load_out && Write_en;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         a_ptr    <= '0;
         b_ptr    <= '0;
         c_ptr    <= '0;
         finished <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (host_start) begin
                  state    <= RUN;
                  a_ptr    <= '0;
                  b_ptr    <= '0;
                  c_ptr    <= '0;
                  finished <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               if (load_out) begin
                  a_ptr <= '0;
                  b_ptr <= '0;
                  c_ptr <= '0;
               end else begin
                  for (int unsigned l = 0; l < LANES; l++) begin
                     if (a_en[l]) a_ptr[l] <= ADDR_WIDTH'(ptr_next(32'(a_ptr[l]), NN));
                     if (b_en[l]) b_ptr[l] <= ADDR_WIDTH'(ptr_next(32'(b_ptr[l]), NN));
                  end
                  if (c_wr) begin
                     c_ptr <= c_ptr + 1'b1;
                     if (c_ptr == (ADDR_WIDTH+1)'(NN - 1)) begin
                        state    <= DONE;
                        finished <= 1'b1;
                        busy     <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   strassen_mat_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (NN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RD_PORTS   (LANES)
   ) u_a_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (a_wr),
      .wr_addr (host_addr),
      .wr_data (host_wdata),
      .rd_en   (a_en),
      .rd_addr (a_ptr),
      .rd_data (a_data)
   );

   strassen_mat_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (NN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RD_PORTS   (LANES)
   ) u_b_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (b_wr),
      .wr_addr (host_addr),
      .wr_data (host_wdata),
      .rd_en   (b_en),
      .rd_addr (b_ptr),
      .rd_data (b_data)
   );

   strassen_mat_store #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (NN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .RD_PORTS   (1)
   ) u_c_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (c_wr),
      .wr_addr (c_ptr[ADDR_WIDTH-1:0]),
      .wr_data (C_out),
      .rd_en   (1'b1),
      .rd_addr (host_rd_addr),
      .rd_data (host_rdata)
   );

   always_comb begin
      A_in   = a_data[0];
      A_in_1 = a_data[1];
      A_in_2 = a_data[2];
      B_in   = b_data[0];
      B_in_1 = b_data[1];
      B_in_2 = b_data[2];
   end

endmodule

// File: tb/tb_strassen_mem_server.sv
// Scoreboard bench for strassen_mem_server (DIM=2): stimulus updates a
// behavioural model and queues expected outputs; a negedge monitor compares.
module tb_strassen_mem_server;

   localparam int DW = 16;
   localparam int AW = 2;
   localparam int NN = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          host_wr_en, host_sel, host_start, Write_en, load_out;
   logic [AW-1:0] host_addr, host_rd_addr;
   logic [DW-1:0] host_wdata, C_out, host_rdata;
   logic [2:0]    A_read_en, B_read_en;
   logic [DW-1:0] A_in, A_in_1, A_in_2, B_in, B_in_1, B_in_2;
   logic          finished, busy;

   strassen_mem_server #(.DATA_WIDTH(DW), .DIM(2)) dut (
      .clk(clk), .rst(rst),
      .host_wr_en(host_wr_en), .host_sel(host_sel), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_start(host_start),
      .host_rd_addr(host_rd_addr), .host_rdata(host_rdata),
      .A_read_en(A_read_en), .B_read_en(B_read_en),
      .A_in(A_in), .A_in_1(A_in_1), .A_in_2(A_in_2),
      .B_in(B_in), .B_in_1(B_in_1), .B_in_2(B_in_2),
      .C_out(C_out), .Write_en(Write_en), .load_out(load_out),
      .finished(finished), .busy(busy)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      int            due;
      int            sig;
      logic [DW-1:0] val;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int failures = 0;

   // Reference model: mode 0 = idle, 1 = running, 2 = done.
   int            mode;
   logic [DW-1:0] ma[NN], mb[NN], mc[NN];
   bit            cv[NN];
   int            ap[3], bp[3], cp;
   logic [DW-1:0] ao[3], bo[3], hr;
   bit            hr_ok, fin, bsy;

   function automatic string sig_name(input int s);
      case (s)
         0: return "A_in";    1: return "A_in_1";  2: return "A_in_2";
         3: return "B_in";    4: return "B_in_1";  5: return "B_in_2";
         6: return "host_rdata"; 7: return "finished";
         default: return "busy";
      endcase
   endfunction

   function automatic logic [DW-1:0] actual(input int s);
      case (s)
         0: return A_in;   1: return A_in_1; 2: return A_in_2;
         3: return B_in;   4: return B_in_1; 5: return B_in_2;
         6: return host_rdata;
         7: return {{(DW-1){1'b0}}, finished};
         default: return {{(DW-1){1'b0}}, busy};
      endcase
   endfunction

   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= edge_cnt) begin
         exp_t e;
         logic [DW-1:0] a;
         e = q.pop_front();
         a = actual(e.sig);
         checks++;
         if (a !== e.val) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", sig_name(e.sig), edge_cnt, a, e.val);
         end
      end
   end

   task automatic model_zero();
      mode = 0; cp = 0; hr = '0; hr_ok = 1'b1; fin = 1'b0; bsy = 1'b0;
      for (int l = 0; l < 3; l++) begin
         ap[l] = 0; bp[l] = 0; ao[l] = '0; bo[l] = '0;
      end
   endtask

   task automatic push_exp(input int due);
      for (int s = 0; s < 9; s++) begin
         logic [DW-1:0] v;
         if (s < 3)       v = ao[s];
         else if (s < 6)  v = bo[s-3];
         else if (s == 6) v = hr;
         else if (s == 7) v = {{(DW-1){1'b0}}, fin};
         else             v = {{(DW-1){1'b0}}, bsy};
         if (s != 6 || hr_ok) q.push_back('{due, s, v});
      end
   endtask

   // Apply current inputs to the model, queue the post-edge outputs, advance one clock.
   task automatic step();
      if (!rst) begin
         model_zero();
      end else begin
         hr_ok = cv[host_rd_addr];
         hr    = mc[host_rd_addr];
         if (mode == 1) begin
            if (load_out) begin
               for (int l = 0; l < 3; l++) begin ap[l] = 0; bp[l] = 0; end
               cp = 0;
            end else begin
               for (int l = 0; l < 3; l++) begin
                  if (A_read_en[l]) begin ao[l] = ma[ap[l]]; ap[l] = (ap[l] + 1) % NN; end
                  if (B_read_en[l]) begin bo[l] = mb[bp[l]]; bp[l] = (bp[l] + 1) % NN; end
               end
               if (Write_en) begin
                  mc[cp] = C_out; cv[cp] = 1'b1; cp++;
                  if (cp == NN) begin mode = 2; fin = 1'b1; bsy = 1'b0; end
               end
            end
         end else begin
            if (host_wr_en) begin
               if (host_sel) mb[host_addr] = host_wdata;
               else          ma[host_addr] = host_wdata;
            end
            if (host_start) begin
               mode = 1; cp = 0; fin = 1'b0; bsy = 1'b1;
               for (int l = 0; l < 3; l++) begin ap[l] = 0; bp[l] = 0; end
            end
         end
      end
      push_exp(edge_cnt + 1);
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset: outputs must be zero at the next negedge, before any clock edge.
   task automatic assert_async_reset();
      rst = 1'b0;
      model_zero();
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].due >= edge_cnt) q.delete(i);
      push_exp(edge_cnt);
   endtask

   task automatic idle_in();
      host_wr_en = 0; host_sel = 0; host_addr = '0; host_wdata = '0; host_start = 0;
      A_read_en = '0; B_read_en = '0; Write_en = 0; load_out = 0; C_out = '0;
   endtask

   task automatic host_wr(input bit sel, input int addr, input int data);
      idle_in();
      host_wr_en = 1; host_sel = sel; host_addr = AW'(addr); host_wdata = DW'(data);
      step();
   endtask

   task automatic pulse_start();
      idle_in(); host_start = 1; step();
   endtask

   task automatic c_write(input int data);
      idle_in(); Write_en = 1; C_out = DW'(data); step();
   endtask

   initial begin
      for (int i = 0; i < NN; i++) cv[i] = 1'b0;
      rst = 1'b0; host_rd_addr = '0;
      idle_in();
      model_zero();
      @(posedge clk); #1;
      step(); step();
      rst = 1'b1;
      step();

      // Load A = 1..4, B = 5..8, then stream lane A0 alone for four cycles.
      for (int i = 0; i < NN; i++) host_wr(0, i, i + 1);
      for (int i = 0; i < NN; i++) host_wr(1, i, i + 5);
      pulse_start();
      for (int i = 0; i < 4; i++) begin idle_in(); A_read_en = 3'b001; step(); end
      idle_in(); step();

      // All six lanes for five cycles: wrap back to element 0.
      for (int i = 0; i < 5; i++) begin idle_in(); A_read_en = 3'b111; B_read_en = 3'b111; step(); end

      // Fill C; finished after the 4th write; 5th write in DONE ignored.
      c_write(10); c_write(20); c_write(30); c_write(40);
      idle_in(); host_rd_addr = 2; step();
      step();
      c_write(55);
      idle_in(); host_rd_addr = 3; step();
      step();

      // Rewind mid-run: the write alongside load_out is dropped.
      pulse_start();
      idle_in(); Write_en = 1; C_out = 11; A_read_en = 3'b001; step();
      idle_in(); Write_en = 1; C_out = 12; A_read_en = 3'b001; step();
      idle_in(); load_out = 1; Write_en = 1; C_out = 99; A_read_en = 3'b001; step();
      host_wr(0, 0, 77);
      idle_in(); A_read_en = 3'b001; step();
      c_write(21); c_write(22); c_write(23);
      idle_in(); host_rd_addr = 0; step();
      c_write(24);
      for (int i = 0; i < NN; i++) begin idle_in(); host_rd_addr = AW'(i); step(); end

      // Operand write in DONE lands; next run sees it.
      host_wr(0, 0, 77);
      pulse_start();
      idle_in(); A_read_en = 3'b001; step();
      idle_in(); A_read_en = 3'b110; B_read_en = 3'b011; c_write(5);
      idle_in(); A_read_en = 3'b111; step();

      // Reset while running, hold two cycles, then run again.
      assert_async_reset();
      idle_in(); step(); step();
      rst = 1'b1;
      step();
      pulse_start();
      for (int i = 0; i < 3; i++) begin idle_in(); A_read_en = 3'b101; B_read_en = 3'b010; step(); end

      // Randomized traffic in all states.
      for (int i = 0; i < 400; i++) begin
         host_wr_en   = ($urandom % 4) == 0;
         host_sel     = $urandom % 2;
         host_addr    = AW'($urandom);
         host_wdata   = DW'($urandom);
         host_start   = ($urandom % 16) == 0;
         A_read_en    = 3'($urandom);
         B_read_en    = 3'($urandom);
         Write_en     = $urandom % 2;
         C_out        = DW'($urandom);
         load_out     = ($urandom % 25) == 0;
         host_rd_addr = AW'($urandom);
         step();
      end
      idle_in();
      step();
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
